// File: rtl/buyruk_uretici.sv
// Issue side of the buyruk interface: queues upstream operation fields, packs them into a
// 79-bit word and keeps exactly one word in flight until the core completes it or it times out.
module buyruk_uretici #(
    parameter int FIFO_DERINLIK = 4,
    parameter int ZAMAN_ASIMI   = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             giris_gecerli,
    output logic                             giris_hazir,
    input  logic [12:0]                      giris_adres,
    input  logic [31:0]                      giris_sayi1,
    input  logic [31:0]                      giris_sayi2,
    input  logic [1:0]                       giris_islem,
    output logic [78:0]                      buyruk,
    output logic                             buyruk_gecerli,
    input  logic                             sonuc_gecerli,
    output logic                             mesgul,
    output logic                             zaman_asimi,
    output logic [$clog2(FIFO_DERINLIK):0]   bekleyen
);
    localparam int PW = $clog2(FIFO_DERINLIK);
    localparam int TW = $clog2(ZAMAN_ASIMI);
    localparam logic [PW:0]   DOLU = (PW+1)'(FIFO_DERINLIK);
    localparam logic [TW-1:0] SON  = TW'(ZAMAN_ASIMI - 1);

    typedef struct packed {
        logic [12:0] adres;
        logic [31:0] sayi1;
        logic [31:0] sayi2;
        logic [1:0]  islem;
    } buyruk_t;

    typedef enum logic [1:0] {BOS, GONDER, BEKLE} durum_t;

    durum_t          durum, durum_sonraki;
    buyruk_t         kuyruk [FIFO_DERINLIK];
    buyruk_t         buyruk_r;
    logic [PW-1:0]   yaz_ptr, oku_ptr;
    logic [TW-1:0]   sayac;
    logic            yaz, al;

    assign giris_hazir = (bekleyen != DOLU);
    assign yaz         = giris_gecerli & giris_hazir;
    assign buyruk      = buyruk_r;

    // Storage needs no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (yaz)
            kuyruk[yaz_ptr] <= '{adres: giris_adres, sayi1: giris_sayi1,
                                 sayi2: giris_sayi2, islem: giris_islem};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            yaz_ptr  <= '0;
            oku_ptr  <= '0;
            bekleyen <= '0;
        end else begin
            if (yaz) yaz_ptr <= yaz_ptr + 1'b1;
            if (al)  oku_ptr <= oku_ptr + 1'b1;
            case ({yaz, al})
                2'b10:   bekleyen <= bekleyen + 1'b1;
                2'b01:   bekleyen <= bekleyen - 1'b1;
                default: bekleyen <= bekleyen;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum    <= BOS;
            buyruk_r <= '0;
            sayac    <= '0;
        end else begin
            durum <= durum_sonraki;
            if (al)
                buyruk_r <= kuyruk[oku_ptr];
            if (durum == GONDER)
                sayac <= '0;
            else if (durum == BEKLE)
                sayac <= sayac + 1'b1;
        end
    end

    // Completion is tested before the terminal count so a coincident pulse is never a timeout.
    always_comb begin
        durum_sonraki  = durum;
        al             = 1'b0;
        buyruk_gecerli = 1'b0;
        mesgul         = 1'b0;
        zaman_asimi    = 1'b0;
        case (durum)
            BOS: begin
                if (bekleyen != '0) begin
                    al            = 1'b1;
                    durum_sonraki = GONDER;
                end
            end
            GONDER: begin
                buyruk_gecerli = 1'b1;
                mesgul         = 1'b1;
                durum_sonraki  = BEKLE;
            end
            BEKLE: begin
                mesgul = 1'b1;
                if (sonuc_gecerli) begin
                    durum_sonraki = BOS;
                end else if (sayac == SON) begin
                    zaman_asimi   = 1'b1;
                    durum_sonraki = BOS;
                end
            end
            default: durum_sonraki = BOS;
        endcase
    end
endmodule
